// File: rtl/bridge_pkg.sv
// bridge_pkg: shared word geometry, FSM state and byte-counter types for the bridge byte read path
package bridge_pkg;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef logic [1:0] byte_idx_t;
endpackage

// File: rtl/valid_delay.sv
// valid_delay: N-stage 1-bit shift register (in_i -> out_o after N clk), sync active-low reset_n clears all stages
module valid_delay #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic out_o
);
  logic [N-1:0] sr_q;
  always_ff @(posedge clk) begin
    if (!reset_n) sr_q <= '0;
    else begin
      sr_q[0] <= in_i;
      for (int i = 1; i < N; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign out_o = sr_q[N-1];
endmodule

// File: rtl/bytes_to_bridge.sv
// bytes_to_bridge: turns one bridge word read into four byte reads and returns the big-endian word with a done pulse
// ports: clk, reset_n (sync active-low); bridge_addr/bridge_rd in, bridge_rd_data/bridge_rd_done/busy out;
//        mem_address/mem_rd out to byte memory, mem_rd_data in (MEM_LATENCY cycles after mem_rd)
module bytes_to_bridge
  import bridge_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] bridge_addr,
  input  logic        bridge_rd,
  output logic [31:0] bridge_rd_data,
  output logic        bridge_rd_done,
  output logic        busy,
  output logic [31:0] mem_address,
  output logic        mem_rd,
  input  logic [7:0]  mem_rd_data
);
  state_t      state_q, state_d;
  byte_idx_t   iss_q, iss_d, cap_q, cap_d;
  logic [31:0] word_q, word_d, data_q, data_d, addr_q, addr_d;
  logic        rd_q, rd_d, done_q, done_d, dv, start, last;
  valid_delay #(.N(MEM_LATENCY)) u_dly (
    .clk    (clk),
    .reset_n(reset_n),
    .in_i   (rd_q),
    .out_o  (dv)
  );
  always_comb begin
    start   = state_q == IDLE && bridge_rd;
    last    = dv && cap_q == byte_idx_t'(BYTES_PER_WORD - 1);
    // issue counter wraps to 0 after the fourth strobe, which ends ISSUE
    rd_d    = start || (state_q == ISSUE && iss_q != '0);
    addr_d  = start ? bridge_addr : (rd_d ? addr_q + 32'd1 : addr_q);
    iss_d   = rd_d ? iss_q + 2'd1 : iss_q;
    cap_d   = dv ? cap_q + 2'd1 : cap_q;
    word_d  = dv ? {word_q[23:0], mem_rd_data} : word_q;
    data_d  = last ? word_d : data_q;
    done_d  = last;
    state_d = start ? ISSUE : (state_q == ISSUE && !rd_d) ? WAIT : last ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      iss_q   <= '0;
      cap_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      cap_q   <= cap_d;
      word_q  <= word_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end
  assign bridge_rd_data = data_q;
  assign bridge_rd_done = done_q;
  assign busy           = state_q != IDLE;
  assign mem_address    = addr_q;
  assign mem_rd         = rd_q;
endmodule

// File: tb/tb_bytes_to_bridge.sv
// tb_bytes_to_bridge: scoreboard bench running the same directed reads against latency 1, 2 and 8 builds
module tb_bytes_to_bridge;
  typedef struct {logic [31:0] v; int c;} ev_t;
  logic clk = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] mem(input logic [31:0] a);
    case (a)
      32'h100: mem = 8'h11;
      32'h101: mem = 8'h22;
      32'h102: mem = 8'h33;
      32'h103: mem = 8'h44;
      32'h104: mem = 8'hAA;
      32'h105: mem = 8'hBB;
      32'h106: mem = 8'hCC;
      32'h107: mem = 8'hDD;
      32'hFFFF_FFFE: mem = 8'hDE;
      32'hFFFF_FFFF: mem = 8'hAD;
      32'h0: mem = 8'hBE;
      32'h1: mem = 8'hEF;
      32'h200: mem = 8'h01;
      32'h201: mem = 8'h02;
      32'h202: mem = 8'h03;
      32'h203: mem = 8'h04;
      default: mem = a[7:0] ^ 8'hC3;
    endcase
  endfunction
  task automatic chk(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (L=%0d): got %h expected %h", nm, l, act, exp);
    end
  endtask
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int L = g == 0 ? 1 : g == 1 ? 2 : 8;
    logic        reset_n, bridge_rd, rd_done, busy, mem_rd;
    logic [31:0] bridge_addr, rd_data, mem_address;
    logic [7:0]  mem_rd_data;
    logic [L-1:0] pv = '0;
    logic [31:0] pa [L];
    logic [31:0] held = '0;
    bit          fin = 1'b0;
    ev_t         dq[$], aq[$];
    ev_t         e;
    bytes_to_bridge #(.MEM_LATENCY(L)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bridge_addr   (bridge_addr),
      .bridge_rd     (bridge_rd),
      .bridge_rd_data(rd_data),
      .bridge_rd_done(rd_done),
      .busy          (busy),
      .mem_address   (mem_address),
      .mem_rd        (mem_rd),
      .mem_rd_data   (mem_rd_data)
    );
    always @(posedge clk) begin
      pv[0] <= mem_rd;
      pa[0] <= mem_address;
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
    assign mem_rd_data = pv[L-1] ? mem(pa[L-1]) : 8'hEE;
    always @(negedge clk) begin
      if (reset_n) begin
        if (mem_rd) begin
          if (aq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_mem_rd (L=%0d): got addr %h expected none", L, mem_address);
          end else begin
            e = aq.pop_front();
            chk("mem_address", L, mem_address, e.v);
            chk("mem_rd_cycle", L, cyc, e.c);
          end
        end
        if (rd_done) begin
          if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done (L=%0d): got data %h expected no done", L, rd_data);
          end else begin
            e = dq.pop_front();
            chk("done_data", L, rd_data, e.v);
            chk("done_cycle", L, cyc, e.c);
            held = e.v;
          end
        end else chk("held_data", L, rd_data, held);
      end
    end
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input bit exp_done);
      bridge_rd = 1'b1;
      bridge_addr = a;
      for (int i = 0; i < 4; i++) aq.push_back('{a + 32'(i), cyc + 1 + i});
      if (exp_done) dq.push_back('{d, cyc + 5 + L});
      @(negedge clk);
      bridge_rd = 1'b0;
    endtask
    task automatic zeros(input string nm);
      chk({nm, "_data"}, L, rd_data, 32'h0);
      chk({nm, "_done"}, L, 32'(rd_done), 32'h0);
      chk({nm, "_busy"}, L, 32'(busy), 32'h0);
      chk({nm, "_addr"}, L, mem_address, 32'h0);
      chk({nm, "_rd"}, L, 32'(mem_rd), 32'h0);
    endtask
    initial begin
      reset_n = 1'b0;
      bridge_rd = 1'b0;
      bridge_addr = '0;
      repeat (2) @(negedge clk);
      zeros("reset");
      reset_n = 1'b1;
      @(negedge clk);
      issue(32'h100, 32'h1122_3344, 1'b1);
      chk("busy_issue", L, 32'(busy), 32'h1);
      repeat (L + 4) @(negedge clk);
      chk("busy_done", L, 32'(busy), 32'h0);
      issue(32'h104, 32'hAABB_CCDD, 1'b1);
      @(negedge clk);
      bridge_rd = 1'b1;
      bridge_addr = 32'h300;
      @(negedge clk);
      bridge_rd = 1'b0;
      repeat (L + 4) @(negedge clk);
      issue(32'hFFFF_FFFE, 32'hDEAD_BEEF, 1'b1);
      repeat (L + 6) @(negedge clk);
      issue(32'h100, 32'h0, 1'b0);
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1 held = '0;
      @(negedge clk);
      zeros("midreset");
      reset_n = 1'b1;
      @(negedge clk);
      issue(32'h200, 32'h0102_0304, 1'b1);
      repeat (L + 6) @(negedge clk);
      chk("pending_mem", L, aq.size(), 32'h0);
      chk("pending_done", L, dq.size(), 32'h0);
      fin = 1'b1;
    end
  end
  initial begin
    fork
      wait (inst[0].fin && inst[1].fin && inst[2].fin);
      #100000;
    join_any
    if (!(inst[0].fin && inst[1].fin && inst[2].fin)) begin
      checks++;
      errors++;
      $display("FAIL timeout: got unfinished stimulus expected completion");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
